// File: rtl/ed25519_pkg.sv
// Shared types and sizing for the ED25519 host link.
package ed25519_pkg;

    localparam int BEAT_W   = 64;
    localparam int COORD_W  = 256;
    localparam int TX_BEATS = 12;
    localparam int RX_BEATS = 8;
    localparam int JOB_W    = 3 * COORD_W;
    localparam int RSP_W    = 2 * COORD_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_RECV,
        S_RESP
    } host_state_t;

endpackage

// File: rtl/ed25519_host_link_rsp_deser.sv
// Result deserialiser: collects 8 beats MSW first into {x, y}.
module ed25519_rsp_deser
    import ed25519_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic               i_load,
    input  logic [BEAT_W-1:0]  i_beat,
    output logic               o_last,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y
);

    logic [RSP_W-1:0] data_q, data_d;
    logic [3:0]       cnt_q, cnt_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        o_last = 1'b0;
        if (i_clr) begin
            data_d = '0;
            cnt_d  = '0;
        end else if (i_load) begin
            data_d = {data_q[RSP_W-BEAT_W-1:0], i_beat};
            if (cnt_q == 4'(RX_BEATS - 1)) begin
                cnt_d  = '0;
                o_last = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_x = data_q[RSP_W-1:COORD_W];
    assign o_y = data_q[COORD_W-1:0];

endmodule

// File: rtl/ed25519_host_link.sv
// Host-side job serialiser / result deserialiser for the ED25519 accelerator.
// Optional rx watchdog enabled by defining ED25519_HOST_TIMEOUT_EN.
module ed25519_host_link
    import ed25519_pkg::*;
#(
    parameter int BEAT_W_P = BEAT_W,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [COORD_W-1:0]   i_req_m,
    input  logic [COORD_W-1:0]   i_req_x,
    input  logic [COORD_W-1:0]   i_req_y,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic [BEAT_W_P-1:0]  o_tx_data,
    input  logic                 i_rx_valid,
    output logic                 o_rx_ready,
    input  logic [BEAT_W_P-1:0]  i_rx_data,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [COORD_W-1:0]   o_rsp_x,
    output logic [COORD_W-1:0]   o_rsp_y,
    output logic                 o_rsp_timeout
);

    localparam int SH_W = JOB_W - BEAT_W_P;

    host_state_t         state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                tx_valid_q, tx_valid_d;
    logic [BEAT_W_P-1:0] tx_data_q, tx_data_d;
    logic                rx_ready_q, rx_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [SH_W-1:0]     shreg_q, shreg_d;

    logic req_hs, tx_hs, rx_hs, rsp_hs;
    logic deser_clr, deser_last;

`ifdef ED25519_HOST_TIMEOUT_EN
    logic        timeout_q, timeout_d;
    logic [19:0] wd_q, wd_d;
`endif

    assign req_hs = i_req_valid & req_ready_q;
    assign tx_hs  = tx_valid_q & i_tx_ready;
    assign rx_hs  = i_rx_valid & rx_ready_q;
    assign rsp_hs = rsp_valid_q & i_rsp_ready;

    ed25519_rsp_deser u_deser (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (deser_clr),
        .i_load (rx_hs),
        .i_beat (i_rx_data),
        .o_last (deser_last),
        .o_x    (o_rsp_x),
        .o_y    (o_rsp_y)
    );

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        rx_ready_d  = rx_ready_q;
        rsp_valid_d = rsp_valid_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        deser_clr   = 1'b0;
`ifdef ED25519_HOST_TIMEOUT_EN
        timeout_d   = timeout_q;
        wd_d        = wd_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_hs) begin
                    req_ready_d = 1'b0;
                    tx_valid_d  = 1'b1;
                    tx_data_d   = i_req_m[COORD_W-1 -: BEAT_W_P];
                    shreg_d     = {i_req_m[COORD_W-BEAT_W_P-1:0],
                                   i_req_x, i_req_y};
                    cnt_d       = '0;
                    deser_clr   = 1'b1;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_hs) begin
                    if (cnt_q == 4'(TX_BEATS - 1)) begin
                        tx_valid_d = 1'b0;
                        tx_data_d  = '0;
                        cnt_d      = '0;
                        rx_ready_d = 1'b1;
                        state_d    = S_RECV;
`ifdef ED25519_HOST_TIMEOUT_EN
                        wd_d       = '0;
`endif
                    end else begin
                        cnt_d     = cnt_q + 4'd1;
                        tx_data_d = shreg_q[SH_W-1 -: BEAT_W_P];
                        shreg_d   = {shreg_q[SH_W-BEAT_W_P-1:0],
                                     {BEAT_W_P{1'b0}}};
                    end
                end
            end
            S_RECV: begin
`ifdef ED25519_HOST_TIMEOUT_EN
                wd_d = rx_hs ? 20'd0 : wd_q + 20'd1;
`endif
                if (deser_last) begin
                    rx_ready_d  = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
`ifdef ED25519_HOST_TIMEOUT_EN
                else if (!rx_hs &&
                         wd_q == 20'(TIMEOUT_CYCLES - 1)) begin
                    rx_ready_d  = 1'b0;
                    rsp_valid_d = 1'b1;
                    timeout_d   = 1'b1;
                    deser_clr   = 1'b1;
                    state_d     = S_RESP;
                end
`endif
            end
            S_RESP: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
`ifdef ED25519_HOST_TIMEOUT_EN
                    timeout_d   = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            rx_ready_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            cnt_q       <= '0;
            shreg_q     <= '0;
`ifdef ED25519_HOST_TIMEOUT_EN
            timeout_q   <= 1'b0;
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            rx_ready_q  <= rx_ready_d;
            rsp_valid_q <= rsp_valid_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
`ifdef ED25519_HOST_TIMEOUT_EN
            timeout_q   <= timeout_d;
            wd_q        <= wd_d;
`endif
        end
    end

    assign o_req_ready = req_ready_q;
    assign o_tx_valid  = tx_valid_q;
    assign o_tx_data   = tx_data_q;
    assign o_rx_ready  = rx_ready_q;
    assign o_rsp_valid = rsp_valid_q;
`ifdef ED25519_HOST_TIMEOUT_EN
    assign o_rsp_timeout = timeout_q;
`else
    assign o_rsp_timeout = 1'b0;
`endif

endmodule
